buck_dpwm: RTL and testbench
============================

// Module: buck_dpwm
// PURPOSE
//  Digital PWM modulator with soft-start, dead-time insertion and over-current latch-off.
//  Sits directly upstream of the buck power stage model and replaces the comparator + pwl_saw modulation path.
//  Converts a duty-cycle command into non-overlapping high-side/low-side gate enables at fsw = fclk/PERIOD.
//  Example: 100 MHz clk with PERIOD=100 gives fsw = 1 MHz.
// PARAMETERS
//  NB      8                  width of duty_cmd and cnt; requires 2^NB > PERIOD
//  PERIOD  100                clk cycles per switching period
//  DT      3                  dead-time in clk cycles, applied on both edges; DT>=1
//  DMAX    PERIOD-2*DT        maximum effective duty in cycles; duty_cmd is clamped to this value
//  SS_INC  1                  soft-start duty increment per period, in cycles
// PORTS
//  clk       in   1    system clock
//  rstn      in   1    asynchronous active-low reset
//  en        in   1    converter enable, level sensitive
//  duty_cmd  in   NB   target duty in clk cycles (0..2^NB-1)
//  ocp       in   1    over-current flag, synchronous to clk
//  hs_on     out  1    high-side switch enable, registered
//  ls_on     out  1    low-side switch enable, registered
//  cnt       out  NB   period counter, 0..PERIOD-1
//  state     out  2    00 IDLE, 01 SOFTSTART, 10 RUN, 11 FAULT
//  fault     out  1    1 while state==FAULT
// BEHAVIOUR
//  Reset (rstn=0, async): state=IDLE, cnt=0, D=0, duty_ss=0; hs_on=ls_on=fault=0.
//  Counter: counts 0..PERIOD-1 and wraps to 0 in SOFTSTART/RUN. It is held at 0 in IDLE and FAULT.
//  Shadow duty D:
//   - updated only on the wrap edge (cnt==PERIOD-1 -> 0), so every period uses one constant D.
//   - C = min(duty_cmd, DMAX).
//   - In SOFTSTART, D = duty_ss; in RUN, D = C.
//  Outputs are registered, computed from the next-state cnt, D and state. In each cycle:
//   hs_on==1 iff state in {SOFTSTART,RUN} && DT <= cnt < D
//   ls_on==1 iff state in {SOFTSTART,RUN} && D+DT <= cnt < PERIOD
//  Consequences:
//   - Both outputs are never 1 together. At least DT cycles both-low follow every transition.
//   - D<=DT: hs_on stays 0 for the whole period.
//   - D=0: ls_on is high for cnt in [DT,PERIOD).
//  FSM (priority: rstn > en=0 > ocp):
//   IDLE      -> SOFTSTART when en=1; duty_ss=0, cnt starts at 0 on the next cycle.
//   SOFTSTART -> each wrap: duty_ss = min(duty_ss+SS_INC, C).
//                Go to RUN on the wrap where duty_ss==C before the increment.
//   RUN       -> C tracked at every wrap. If C drops below D, it takes effect at the next wrap, never mid-period.
//   FAULT     -> entered on the first edge with ocp=1 in SOFTSTART/RUN.
//                hs_on=ls_on=0 from that same edge; cnt=0. The fault is latched regardless of later ocp.
//   any state -> IDLE on the first edge with en=0: outputs 0, cnt=0, duty_ss=0, fault cleared.
//  Simultaneous en=0 and ocp=1: IDLE wins; fault is not set.
//  rstn asserted mid-period: outputs drop immediately (async). After release, the FSM restarts from IDLE.
//  duty_cmd changes mid-period are ignored until the wrap. Values > DMAX are saturated, with no wrap-around.
// TESTING
//  1 Reset/idle: rstn=0 then 1, en=0 for 300 cycles -> hs_on=ls_on=0, cnt=0, state=00.
//  2 Soft-start: en=1, duty_cmd=40.
//     -> D steps 0,1,..,40 per period; state=10 after 41 wraps.
//     -> In RUN: hs_on high for cnt 3..39 (37 cycles), ls_on high for cnt 43..99 (57 cycles).
//  3 Clamp/extremes in RUN:
//     - duty_cmd=255 -> D=94, hs_on for 91 cycles, ls_on for cnt 97..99 (3 cycles).
//     - duty_cmd=0 -> hs_on never high.
//     - duty_cmd=2 -> hs_on never high.
//  4 Mid-period change: in RUN at cnt=20 set duty_cmd 40->60.
//     -> The current period still ends hs_on at cnt 39; the next period runs hs_on for cnt 3..59.
//  5 OCP: pulse ocp=1 for 1 cycle at cnt=25 in RUN.
//     -> Next edge: state=11, fault=1, hs_on=ls_on=0.
//     -> Stays latched; en=0 gives IDLE; en=1 restarts soft-start from D=0.
//  6 Overlap/race: every cycle assert !(hs_on&&ls_on).
//     - en=0 and ocp=1 on the same cycle -> state=00, fault=0.
//     - rstn pulse mid-RUN -> outputs 0 without waiting for a clock edge.

Source files
------------

// File: rtl/buck_dpwm.sv
// Digital PWM modulator for a buck stage: soft-start, dead-time insertion
// and latched over-current shutdown, switching at fclk/PERIOD.
//
// Ports:
//   clk      : system clock
//   rstn     : asynchronous active-low reset
//   en       : converter enable (level)
//   duty_cmd : target duty in clk cycles, saturated to DMAX
//   ocp      : over-current flag, synchronous to clk
//   hs_on    : high-side gate enable (registered)
//   ls_on    : low-side gate enable (registered)
//   cnt      : period counter, 0..PERIOD-1
//   state    : 00 idle, 01 soft-start, 10 run, 11 fault
//   fault    : high while in the fault state
module buck_dpwm #(
   parameter int NB     = 8,
   parameter int PERIOD = 100,
   parameter int DT     = 3,
   parameter int DMAX   = PERIOD - 2 * DT,
   parameter int SS_INC = 1
) (
   input  logic          clk,
   input  logic          rstn,
   input  logic          en,
   input  logic [NB-1:0] duty_cmd,
   input  logic          ocp,
   output logic          hs_on,
   output logic          ls_on,
   output logic [NB-1:0] cnt,
   output logic [1:0]    state,
   output logic          fault
);

   typedef enum logic [1:0] {
      IDLE      = 2'b00,
      SOFTSTART = 2'b01,
      RUN       = 2'b10,
      FAULT     = 2'b11
   } state_t;

   localparam logic [NB-1:0] LAST   = NB'(PERIOD - 1);
   localparam logic [NB-1:0] DT_V   = NB'(DT);
   localparam logic [NB-1:0] DMAX_V = NB'(DMAX);
   localparam logic [NB-1:0] SS_V   = NB'(SS_INC);

   state_t        cur;
   state_t        nxt;
   logic [NB-1:0] d;
   logic [NB-1:0] duty_ss;
   logic [NB-1:0] cnt_n;
   logic [NB-1:0] d_n;
   logic [NB-1:0] ss_n;
   logic [NB-1:0] c;
   logic [NB-1:0] ss_step;
   logic [NB:0]   ss_sum;
   logic [NB:0]   ls_lo;
   logic          wrap;
   logic          active;
   logic          hs_n;
   logic          ls_n;

   // Saturated command and the next soft-start ramp value, which never
   // overshoots the (possibly lowered) command.
   always_comb begin
      c       = (duty_cmd > DMAX_V) ? DMAX_V : duty_cmd;
      ss_sum  = {1'b0, duty_ss} + {1'b0, SS_V};
      ss_step = (ss_sum > {1'b0, c}) ? c : ss_sum[NB-1:0];
      wrap    = (cnt == LAST);
   end

   always_comb begin
      nxt   = cur;
      cnt_n = cnt;
      d_n   = d;
      ss_n  = duty_ss;
      if (!en) begin
         nxt   = IDLE;
         cnt_n = '0;
         d_n   = '0;
         ss_n  = '0;
      end else begin
         unique case (cur)
            IDLE: begin
               nxt   = SOFTSTART;
               cnt_n = '0;
               d_n   = '0;
               ss_n  = '0;
            end
            SOFTSTART: begin
               if (ocp) begin
                  nxt   = FAULT;
                  cnt_n = '0;
               end else if (wrap) begin
                  cnt_n = '0;
                  if (duty_ss == c) begin
                     nxt = RUN;
                     d_n = c;
                  end else begin
                     ss_n = ss_step;
                     d_n  = ss_step;
                  end
               end else begin
                  cnt_n = cnt + NB'(1);
               end
            end
            RUN: begin
               if (ocp) begin
                  nxt   = FAULT;
                  cnt_n = '0;
               end else if (wrap) begin
                  cnt_n = '0;
                  d_n   = c;
               end else begin
                  cnt_n = cnt + NB'(1);
               end
            end
            FAULT: begin
               cnt_n = '0;
            end
         endcase
      end
   end

   // Gate enables are derived from the next-cycle counter and duty so the
   // registered outputs line up with the cnt value they belong to.
   always_comb begin
      active = (nxt == SOFTSTART) || (nxt == RUN);
      ls_lo  = {1'b0, d_n} + {1'b0, DT_V};
      hs_n   = active && (cnt_n >= DT_V) && (cnt_n < d_n);
      ls_n   = active && ({1'b0, cnt_n} >= ls_lo);
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         cur     <= IDLE;
         cnt     <= '0;
         d       <= '0;
         duty_ss <= '0;
         hs_on   <= 1'b0;
         ls_on   <= 1'b0;
      end else begin
         cur     <= nxt;
         cnt     <= cnt_n;
         d       <= d_n;
         duty_ss <= ss_n;
         hs_on   <= hs_n;
         ls_on   <= ls_n;
      end
   end

   assign state = cur;
   assign fault = (cur == FAULT);

endmodule

// File: tb/tb_buck_dpwm.sv
// Self-checking bench for buck_dpwm: per-period gate profiles are
// compared against expected records queued when stimulus is applied.
module tb_buck_dpwm;

   localparam int PERIOD = 100;

   logic       clk = 1'b0;
   logic       rstn;
   logic       en;
   logic [7:0] duty_cmd;
   logic       ocp;
   logic       hs_on;
   logic       ls_on;
   logic [7:0] cnt;
   logic [1:0] state;
   logic       fault;

   int total = 0;
   int bad = 0;

   typedef struct packed {
      int         hs_cnt;
      int         hs_first;
      int         hs_last;
      int         ls_cnt;
      int         ls_first;
      logic [1:0] st;
      logic       cnt_ok;
      logic       ovl;
   } res_t;

   typedef struct {
      logic [7:0] cmd;
      res_t       exp;
   } vec_t;

   res_t exp_q[$];

   buck_dpwm dut (
      .clk      (clk),
      .rstn     (rstn),
      .en       (en),
      .duty_cmd (duty_cmd),
      .ocp      (ocp),
      .hs_on    (hs_on),
      .ls_on    (ls_on),
      .cnt      (cnt),
      .state    (state),
      .fault    (fault)
   );

   always #5 clk = ~clk;

   function automatic res_t mk(input int hc, input int hf, input int hl,
                               input int lc, input int lf,
                               input logic [1:0] st);
      res_t r;
      r.hs_cnt   = hc;
      r.hs_first = hf;
      r.hs_last  = hl;
      r.ls_cnt   = lc;
      r.ls_first = lf;
      r.st       = st;
      r.cnt_ok   = 1'b1;
      r.ovl      = 1'b0;
      return r;
   endfunction

   // Soft-start period k runs with D=k and dead-time 3.
   function automatic res_t ss_exp(input int k);
      if (k > 3)
         return mk(k - 3, 3, k - 1, 97 - k, k + 3, 2'b01);
      return mk(0, -1, -1, 97 - k, k + 3, 2'b01);
   endfunction

   task automatic chk(input string name, input int act, input int want);
      total++;
      if (act != want) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", name, act, want);
      end
   endtask

   task automatic check_period(input string name, input res_t got);
      res_t e;
      total++;
      if (exp_q.size() == 0) begin
         bad++;
         $display("FAIL %s: no expected record queued", name);
         return;
      end
      e = exp_q.pop_front();
      if (got != e) begin
         bad++;
         $display("FAIL %s: got hs=%0d[%0d..%0d] ls=%0d@%0d st=%0d ok=%0d ov=%0d want hs=%0d[%0d..%0d] ls=%0d@%0d st=%0d",
                  name, got.hs_cnt, got.hs_first, got.hs_last,
                  got.ls_cnt, got.ls_first, got.st, got.cnt_ok, got.ovl,
                  e.hs_cnt, e.hs_first, e.hs_last,
                  e.ls_cnt, e.ls_first, e.st);
      end
   endtask

   // Entered at a negedge with cnt==0; leaves at the negedge that starts
   // the following period.
   task automatic measure(input int chg_at, input logic [7:0] chg_val,
                          output res_t r);
      r.hs_cnt   = 0;
      r.hs_first = -1;
      r.hs_last  = -1;
      r.ls_cnt   = 0;
      r.ls_first = -1;
      r.st       = state;
      r.cnt_ok   = 1'b1;
      r.ovl      = 1'b0;
      for (int i = 0; i < PERIOD; i++) begin
         if (int'(cnt) != i) r.cnt_ok = 1'b0;
         if (hs_on && ls_on) r.ovl = 1'b1;
         if (hs_on) begin
            if (r.hs_cnt == 0) r.hs_first = int'(cnt);
            r.hs_last = int'(cnt);
            r.hs_cnt++;
         end
         if (ls_on) begin
            if (r.ls_cnt == 0) r.ls_first = int'(cnt);
            r.ls_cnt++;
         end
         if (i == chg_at) duty_cmd = chg_val;
         @(negedge clk);
      end
   endtask

   task automatic wait_period();
      repeat (PERIOD) @(negedge clk);
   endtask

   initial begin
      vec_t vt[9];
      res_t got;
      int   errs;

      vt[0] = '{8'd40,  mk(37, 3, 39, 57, 43, 2'b10)};
      vt[1] = '{8'd255, mk(91, 3, 93, 3, 97, 2'b10)};
      vt[2] = '{8'd95,  mk(91, 3, 93, 3, 97, 2'b10)};
      vt[3] = '{8'd94,  mk(91, 3, 93, 3, 97, 2'b10)};
      vt[4] = '{8'd0,   mk(0, -1, -1, 97, 3, 2'b10)};
      vt[5] = '{8'd2,   mk(0, -1, -1, 95, 5, 2'b10)};
      vt[6] = '{8'd3,   mk(0, -1, -1, 94, 6, 2'b10)};
      vt[7] = '{8'd4,   mk(1, 3, 3, 93, 7, 2'b10)};
      vt[8] = '{8'd60,  mk(57, 3, 59, 37, 63, 2'b10)};

      rstn     = 1'b0;
      en       = 1'b0;
      ocp      = 1'b0;
      duty_cmd = 8'd40;
      #1;
      chk("rst_hs", int'(hs_on), 0);
      chk("rst_ls", int'(ls_on), 0);
      chk("rst_cnt", int'(cnt), 0);
      chk("rst_state", int'(state), 0);
      chk("rst_fault", int'(fault), 0);
      repeat (3) @(negedge clk);
      rstn = 1'b1;

      errs = 0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (hs_on || ls_on || fault || cnt != 0 || state != 2'b00)
            errs++;
      end
      chk("idle_hold", errs, 0);

      en = 1'b1;
      @(negedge clk);
      chk("ss_entry_state", int'(state), 1);
      chk("ss_entry_cnt", int'(cnt), 0);
      for (int k = 0; k <= 40; k++) begin
         exp_q.push_back(ss_exp(k));
         measure(-1, 8'd0, got);
         check_period($sformatf("ss_d%0d", k), got);
      end
      exp_q.push_back(mk(37, 3, 39, 57, 43, 2'b10));
      measure(-1, 8'd0, got);
      check_period("run_d40", got);

      foreach (vt[i]) begin
         duty_cmd = vt[i].cmd;
         wait_period();
         exp_q.push_back(vt[i].exp);
         measure(-1, 8'd0, got);
         check_period($sformatf("vec_cmd%0d", vt[i].cmd), got);
      end

      duty_cmd = 8'd40;
      wait_period();
      exp_q.push_back(mk(37, 3, 39, 57, 43, 2'b10));
      exp_q.push_back(mk(57, 3, 59, 37, 63, 2'b10));
      measure(20, 8'd60, got);
      check_period("mid_cur", got);
      measure(-1, 8'd0, got);
      check_period("mid_next", got);

      repeat (25) @(negedge clk);
      chk("ocp_pre_cnt", int'(cnt), 25);
      chk("ocp_pre_hs", int'(hs_on), 1);
      ocp = 1'b1;
      @(negedge clk);
      ocp = 1'b0;
      chk("ocp_state", int'(state), 3);
      chk("ocp_fault", int'(fault), 1);
      chk("ocp_hs", int'(hs_on), 0);
      chk("ocp_ls", int'(ls_on), 0);
      chk("ocp_cnt", int'(cnt), 0);
      errs = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (state != 2'b11 || !fault || hs_on || ls_on || cnt != 0)
            errs++;
      end
      chk("ocp_latched", errs, 0);
      en = 1'b0;
      @(negedge clk);
      chk("ocp_clr_state", int'(state), 0);
      chk("ocp_clr_fault", int'(fault), 0);
      en = 1'b1;
      @(negedge clk);
      chk("restart_state", int'(state), 1);
      exp_q.push_back(ss_exp(0));
      measure(-1, 8'd0, got);
      check_period("restart_d0", got);

      duty_cmd = 8'd2;
      repeat (3) wait_period();
      chk("race_pre_state", int'(state), 2);
      en  = 1'b0;
      ocp = 1'b1;
      @(negedge clk);
      ocp = 1'b0;
      chk("race_state", int'(state), 0);
      chk("race_fault", int'(fault), 0);
      chk("race_gates", int'(hs_on | ls_on), 0);

      en = 1'b1;
      @(negedge clk);
      repeat (3) wait_period();
      chk("rst_pre_state", int'(state), 2);
      repeat (50) @(negedge clk);
      chk("rst_pre_ls", int'(ls_on), 1);
      #2;
      rstn = 1'b0;
      #1;
      chk("async_ls", int'(ls_on), 0);
      chk("async_hs", int'(hs_on), 0);
      chk("async_cnt", int'(cnt), 0);
      chk("async_state", int'(state), 0);
      @(negedge clk);
      chk("rst_held_state", int'(state), 0);
      rstn = 1'b1;
      @(negedge clk);
      chk("rst_rel_state", int'(state), 1);
      chk("rst_rel_cnt", int'(cnt), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
